// File: rtl/ddr_deser.sv
// DDR input deserializer: captures din on both clock edges and packs
// PAIRS rise/fall pairs into one word behind a valid/ready output stage.
module ddr_deser #(
    parameter int DATA_WIDTH = 1,
    parameter int PAIRS      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         din,
    input  logic                          en,
    input  logic                          align,
    output logic [2*DATA_WIDTH*PAIRS-1:0] out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int OW = PW * PAIRS;
    localparam int CW = $clog2(PAIRS);
    localparam logic [CW-1:0] LAST = CW'(PAIRS - 1);

    logic [DATA_WIDTH-1:0] rise;
    logic [DATA_WIDTH-1:0] fall;
    logic                  en_r;
    logic [PW-1:0]         pair;
    logic                  pair_vld;
    logic [OW-1:0]         acc;
    logic [CW-1:0]         cnt;
    logic [OW-1:0]         word;
    logic                  complete;

    // Rising-edge capture of din together with its qualifier
    always_ff @(posedge clk) begin
        if (rst) begin
            rise <= '0;
            en_r <= 1'b0;
        end else begin
            rise <= din;
            en_r <= en;
        end
    end

    // Falling-edge capture; contents only matter once a valid pair forms
    always_ff @(negedge clk) begin
        fall <= din;
    end

    // Join the two half-cycle samples into one pair, rise in the low bits
    always_ff @(posedge clk) begin
        if (rst) begin
            pair     <= '0;
            pair_vld <= 1'b0;
        end else begin
            pair     <= {fall, rise};
            pair_vld <= en_r;
        end
    end

    assign complete = pair_vld && !align && (cnt == LAST);

    // Completed word is the accumulator with the final pair merged on top
    always_comb begin
        word = acc;
        word[OW-1 -: PW] = pair;
    end

    // Slot accumulator; align restarts packing and beats an arriving pair
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (align) begin
            cnt <= '0;
        end else if (pair_vld) begin
            acc[cnt*PW +: PW] <= pair;
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    // Output holding register: load, drop with sticky overflow, or drain
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
        end else if (complete) begin
            if (!out_valid || out_ready) begin
                out_data  <= word;
                out_valid <= 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ddr_deser.sv
// Directed-vector bench for ddr_deser (DATA_WIDTH=1, PAIRS=4) with a
// queue scoreboard checked by an independent output monitor.
module tb_ddr_deser;

    logic       clk;
    logic       rst;
    logic [0:0] din;
    logic       en;
    logic       align;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_cyc = 0;
    int gap = 0;
    int words_seen = 0;
    logic [7:0] exp_q[$];
    logic       prev_valid = 1'b0;
    logic [7:0] prev_data = 8'h00;

    ddr_deser #(.DATA_WIDTH(1), .PAIRS(4)) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .en(en),
        .align(align),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Monitor: a word is newly presented when valid follows an idle
    // cycle or a handshake; otherwise a stalled word must hold still.
    always @(negedge clk) begin
        if (out_valid && (!prev_valid || out_ready)) begin
            checks++;
            words_seen++;
            gap = cyc - last_cyc;
            last_cyc = cyc;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word got %h expected none", out_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL word got %h expected %h", out_data, e);
                end
            end
        end else if (out_valid && prev_valid && !out_ready) begin
            checks++;
            if (out_data !== prev_data) begin
                errors++;
                $display("FAIL hold got %h expected %h", out_data, prev_data);
            end
        end
        prev_valid = out_valid;
        prev_data = out_data;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: rise sample r, fall sample f, qualifier e
    task automatic send(input logic r, input logic f, input logic e);
        din = r;
        en = e;
        @(posedge clk);
        #1 din = f;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int c1;
        rst = 1'b1;
        din = '0;
        en = 1'b0;
        align = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        idle(3);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        idle(2);

        // Alternating 1/0 stream, continuous
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 3) exp_q.push_back(8'h55);
            send(1'b1, 1'b0, 1'b1);
        end
        idle(3);
        chk("gap_55", gap, 4);

        // Mixed pairs with latency probe
        exp_q.push_back(8'h93);
        send(1'b1, 1'b1, 1'b1);
        send(1'b0, 1'b0, 1'b1);
        send(1'b1, 1'b0, 1'b1);
        send(1'b0, 1'b1, 1'b1);
        idle(1);
        chk("lat_t1", out_valid, 0);
        idle(1);
        chk("lat_t2", out_valid, 1);
        idle(3);

        // Align discards a partial word
        send(1'b1, 1'b1, 1'b1);
        send(1'b1, 1'b1, 1'b1);
        idle(2);
        align = 1'b1;
        idle(1);
        align = 1'b0;
        exp_q.push_back(8'hAA);
        for (int i = 0; i < 4; i++) send(1'b0, 1'b1, 1'b1);
        idle(4);

        // en gap of 3 cycles between pair 1 and pair 2
        exp_q.push_back(8'hFF);
        send(1'b1, 1'b1, 1'b1);
        c1 = cyc;
        idle(3);
        for (int i = 0; i < 3; i++) send(1'b1, 1'b1, 1'b1);
        idle(4);
        chk("gap_delay", last_cyc - c1, 8);
        chk("ovf_clear", overflow, 0);

        // Backpressure: second word dropped, overflow sticky
        out_ready = 1'b0;
        exp_q.push_back(8'hFF);
        for (int i = 0; i < 4; i++) send(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send(1'b0, 1'b0, 1'b1);
        idle(3);
        chk("bp_ovf", overflow, 1);
        chk("bp_valid", out_valid, 1);
        chk("bp_data", out_data, 8'hFF);
        out_ready = 1'b1;
        idle(2);
        chk("bp_drain", out_valid, 0);
        chk("bp_sticky", overflow, 1);

        // Reset mid-word while a word is held
        out_ready = 1'b0;
        exp_q.push_back(8'h55);
        for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 1'b1);
        idle(2);
        for (int i = 0; i < 3; i++) send(1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mr_valid", out_valid, 0);
        chk("mr_data", out_data, 0);
        chk("mr_ovf", overflow, 0);
        out_ready = 1'b1;
        exp_q.push_back(8'h36);
        send(1'b0, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b1);
        send(1'b1, 1'b1, 1'b1);
        send(1'b0, 1'b0, 1'b1);
        idle(4);

        chk("q_empty", exp_q.size(), 0);
        chk("words", words_seen, 8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_deser.md
DDR_DESER -- requirements
Module: ddr_deser

Interface
REQ-001 Parameter DATA_WIDTH, default 1, width of DDR input lane bus.
REQ-002 Parameter PAIRS, default 4 (range 2..16), number of edge pairs packed per output word.
REQ-003 Port clk  input  1  single clock; din sampled on both edges.
REQ-004 Port rst  input  1  synchronous active-high reset, sampled on rising edge of clk.
REQ-005 Port din  input  DATA_WIDTH  DDR data, stable around both clk edges.
REQ-006 Port en  input  1  qualifies the rising-edge sample of din and the following falling-edge sample as one valid pair.
REQ-007 Port align  input  1  single-cycle pulse; discards the partial word and restarts packing at slot 0.
REQ-008 Port out_data  output  2*DATA_WIDTH*PAIRS  assembled word.
REQ-009 Port out_valid  output  1  out_data holds an unconsumed word.
REQ-010 Port out_ready  input  1  consumer accepts the word when out_valid && out_ready at a rising edge.
REQ-011 Port overflow  output  1  sticky: a completed word was dropped.

Function
REQ-012 Capture: rising edge T samples din into rise register; the falling edge between T and T+1 samples din into fall register.
REQ-013 Pair stage: at rising edge T+1, pair <= {fall, rise} (rise in low DATA_WIDTH bits); pair_vld <= en sampled at T.
REQ-014 Falling-edge register has no reset; its content is don't-care until the first pair with pair_vld=1 after reset.
REQ-015 Accumulator: slot counter cnt, 0..PAIRS-1; valid pair written to bits [2*DATA_WIDTH*(cnt+1)-1 : 2*DATA_WIDTH*cnt]; slot 0 = earliest pair.
REQ-016 Non-final pair (cnt<PAIRS-1): cnt increments; no output change.
REQ-017 Final pair (cnt==PAIRS-1): word = accumulator with final pair merged; cnt wraps to 0 in the same cycle.
REQ-018 Word load: if out_valid==0, or out_valid && out_ready in the same cycle, out_data <= word and out_valid <= 1 at rising edge T+2 (T = edge sampling the final rise sample).
REQ-019 Word drop: if out_valid==1 && out_ready==0 when a word completes, the word is discarded, out_data/out_valid unchanged, overflow <= 1.
REQ-020 Drain: out_valid && out_ready with no word completing clears out_valid next edge; out_data holds last value.
REQ-021 out_data shall not change while out_valid==1 and out_ready==0.
REQ-022 align has priority over a pair in the same cycle: that pair is discarded, cnt <= 0; out_valid/out_data unaffected.
REQ-023 en low gaps: pair_vld=0 pairs are ignored; cnt and accumulator hold; packing resumes in place.
REQ-024 overflow remains 1 until rst; no other clear.
REQ-025 Throughput: one word per PAIRS cycles sustained with out_ready held high; no bubbles.

Reset
REQ-026 rst=1 at a rising edge: rise, pair, pair_vld, accumulator, cnt, out_data, out_valid, overflow all <= 0.
REQ-027 Reset mid-word discards the partial word; first valid pair after rst deasserts lands in slot 0.
REQ-028 Reset while out_valid=1 drops the held word without setting overflow.

Verification (DATA_WIDTH=1, PAIRS=4)
REQ-029 en=1, din=1 on every rising edge and 0 on every falling edge, out_ready=1 -> out_data=8'h55, out_valid pulses every 4 cycles, first word 2 edges after 4th rise sample.
REQ-030 Pairs (rise,fall) = (1,1),(0,0),(1,0),(0,1) -> out_data=8'b10_01_00_11=8'h93.
REQ-031 out_ready=0 across two completed words -> first word held unchanged, second dropped, overflow=1 and stays 1 after out_ready returns high.
REQ-032 align pulse after 2 valid pairs, then 4 pairs of (0,1) -> out_data=8'hAA; no word from the partial pairs.
REQ-033 en=0 for 3 cycles between pair 1 and pair 2 of pairs all (1,1) -> single word 8'hFF, delayed by 3 cycles, no extra output.
REQ-034 rst pulse after 3 valid pairs with out_valid=1 -> out_valid=0, out_data=0, overflow=0; next 4 pairs produce one correct word.
